// File: rtl/ram_seq_pkg.sv
// ram_seq_pkg: shared definitions for the lab_05 RAM address/data sequencer.
//   - MODE switch encodings (mode_e)
//   - sequencer FSM states (state_e)
//   - default RAM geometry (32 words x 4 bits)
package ram_seq_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 4;

    typedef enum logic [1:0] {
        MODE_READ  = 2'b00,
        MODE_WRITE = 2'b01,
        MODE_SCAN  = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_ADDR,
        ST_WAIT,
        ST_CAPTURE,
        ST_CLEAR
    } state_e;

endpackage

// File: rtl/key_cond.sv
// key_cond: conditions one raw active-low push-button into a one-cycle event.
//   2-flop synchroniser -> optional debounce -> falling-edge detector.
// Build option: RAM_SEQ_DEBOUNCE_EN defined  -> level accepted after DEB_CYCLES
//               stable cycles (event DEB_CYCLES+3 cycles after the edge);
//               undefined -> no debounce (event 3 cycles after the edge).
// Ports:
//   CLK, RST_N  clock, asynchronous active-low reset
//   key_n_i     raw button, active-low, asynchronous to CLK
//   ev_o        registered one-cycle pulse on each accepted press
module key_cond #(
    parameter int unsigned DEB_CYCLES = 500_000
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic key_n_i,
    output logic ev_o
);

`ifdef RAM_SEQ_DEBOUNCE_EN
    localparam int unsigned HOLD = DEB_CYCLES;
`else
    // Debounce bypassed; the product keeps the parameter referenced in both builds.
    localparam int unsigned HOLD = 0 * DEB_CYCLES;
`endif

    logic sync1_q, sync2_q;
    logic lvl;
    logic lvl_prev_q;
    logic ev_q;

    // NOTE: every flop here updates with <= so all stages sample the same
    // pre-edge values; blocking assignments would collapse the sync chain.
    // Synchroniser resets to the released (high) level so reset release
    // never looks like a press.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (HOLD == 0) begin : g_bypass
            assign lvl = sync2_q;
        end else begin : g_debounce
            localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;
            logic [CW-1:0] cnt_q;
            logic          stable_q;

            // A new level is accepted only after HOLD consecutive cycles
            // disagreeing with the current stable level.
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b1;
                end else if (sync2_q == stable_q) begin
                    cnt_q    <= '0;
                end else if (cnt_q == CW'(HOLD - 1)) begin
                    cnt_q    <= '0;
                    stable_q <= sync2_q;
                end else begin
                    cnt_q    <= cnt_q + 1'b1;
                end
            end

            assign lvl = stable_q;
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lvl_prev_q <= 1'b1;
            ev_q       <= 1'b0;
        end else begin
            lvl_prev_q <= lvl;
            ev_q       <= lvl_prev_q & ~lvl;
        end
    end

    assign ev_o = ev_q;

endmodule

// File: rtl/ram_seq_ctrl.sv
// ram_seq_ctrl: address/data sequencer in front of the 32x4 LPM RAM.
//   Auto-increment write, step read, timed auto-scan and whole-memory clear;
//   every pointer change is followed by a readback into DISP_DATA.
// Build option: RAM_SEQ_DEBOUNCE_EN (see key_cond) enables key debounce.
// Ports:
//   CLK, RST_N         clock, asynchronous active-low reset
//   STEP_N, LOAD_N     raw active-low push-buttons
//   MODE               00 READ, 01 WRITE, 10 SCAN, 11 CLEAR
//   ADDR_SW, DATA_SW   pointer load value, write data
//   RAM_RDATA          RAM read port (registered-address RAM)
//   RAM_ADDR/RAM_DATA/RAM_WE  RAM write/address port, WE one-cycle pulses
//   DISP_DATA          registered readback of the current address
//   BUSY               high while a sequence is in progress
module ram_seq_ctrl
    import ram_seq_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned SCAN_DIV   = 50_000_000,
    parameter int unsigned DEB_CYCLES = 500_000
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              STEP_N,
    input  logic              LOAD_N,
    input  logic [1:0]        MODE,
    input  logic [ADDR_W-1:0] ADDR_SW,
    input  logic [DATA_W-1:0] DATA_SW,
    input  logic [DATA_W-1:0] RAM_RDATA,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_DATA,
    output logic              RAM_WE,
    output logic [DATA_W-1:0] DISP_DATA,
    output logic              BUSY
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic   step_ev, load_ev, scan_tick;
    mode_e  mode;
    state_e state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, clr_q, clr_d, addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, disp_q, disp_d;
    logic              we_q, we_d;
    logic [PW-1:0]     presc_q, presc_d;

    key_cond #(.DEB_CYCLES(DEB_CYCLES)) u_step_key (
        .CLK(CLK), .RST_N(RST_N), .key_n_i(STEP_N), .ev_o(step_ev)
    );

    key_cond #(.DEB_CYCLES(DEB_CYCLES)) u_load_key (
        .CLK(CLK), .RST_N(RST_N), .key_n_i(LOAD_N), .ev_o(load_ev)
    );

    assign mode = mode_e'(MODE);

    // Prescaler runs only in SCAN mode and is parked at 0 otherwise, so the
    // first tick always comes SCAN_DIV cycles after entering SCAN.
    assign scan_tick = (mode == MODE_SCAN) && (presc_q == PW'(SCAN_DIV - 1));

    always_comb begin
        presc_d = presc_q + 1'b1;
        if (mode != MODE_SCAN || scan_tick) begin
            presc_d = '0;
        end
    end

    // NOTE: every signal gets its hold value before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        clr_d   = clr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        disp_d  = disp_q;
        we_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Priority: load > step > scan tick. Events seen outside
                // IDLE fall through and are lost.
                if (load_ev) begin
                    ptr_d   = ADDR_SW;
                    addr_d  = ADDR_SW;
                    state_d = ST_ADDR;
                end else if (step_ev && mode == MODE_READ) begin
                    ptr_d   = ptr_q + 1'b1;
                    addr_d  = ptr_q + 1'b1;
                    state_d = ST_ADDR;
                end else if (step_ev && mode == MODE_WRITE) begin
                    wdata_d = DATA_SW;
                    we_d    = 1'b1;
                    state_d = ST_WRITE;
                end else if (step_ev && mode == MODE_CLEAR) begin
                    clr_d   = '0;
                    addr_d  = '0;
                    wdata_d = '0;
                    we_d    = 1'b1;
                    state_d = ST_CLEAR;
                end else if (scan_tick) begin
                    ptr_d   = ptr_q + 1'b1;
                    addr_d  = ptr_q + 1'b1;
                    state_d = ST_ADDR;
                end
            end
            // The WE pulse for this write was raised on entry; here the
            // pointer advances so the readback shows the next word.
            ST_WRITE: begin
                ptr_d   = ptr_q + 1'b1;
                addr_d  = ptr_q + 1'b1;
                state_d = ST_ADDR;
            end
            ST_CLEAR: begin
                if (clr_q == '1) begin
                    ptr_d   = '0;
                    addr_d  = '0;
                    state_d = ST_ADDR;
                end else begin
                    clr_d  = clr_q + 1'b1;
                    addr_d = clr_q + 1'b1;
                    we_d   = 1'b1;
                end
            end
            ST_ADDR:    state_d = ST_WAIT;
            ST_WAIT:    state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                disp_d  = RAM_RDATA;
                state_d = ST_IDLE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            clr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            disp_q  <= '0;
            we_q    <= 1'b0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            clr_q   <= clr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            disp_q  <= disp_d;
            we_q    <= we_d;
            presc_q <= presc_d;
        end
    end

    assign RAM_ADDR  = addr_q;
    assign RAM_DATA  = wdata_q;
    assign RAM_WE    = we_q;
    assign DISP_DATA = disp_q;
    assign BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// tb_ram_seq_ctrl: directed bench for ram_seq_ctrl (debounce disabled,
// SCAN_DIV=10). Stimulus pushes the hand-computed {RAM_ADDR, DISP_DATA}
// expected at the end of each readback; a monitor pops and compares on
// every falling edge of BUSY.
module tb_ram_seq_ctrl;
    import ram_seq_pkg::*;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       STEP_N = 1'b1;
    logic       LOAD_N = 1'b1;
    logic [1:0] MODE = MODE_READ;
    logic [4:0] ADDR_SW = '0;
    logic [3:0] DATA_SW = '0;
    logic [3:0] RAM_RDATA;
    logic [4:0] RAM_ADDR;
    logic [3:0] RAM_DATA;
    logic       RAM_WE;
    logic [3:0] DISP_DATA;
    logic       BUSY;

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_q[$];

    // RAM model: 32x4, registered read address.
    logic [3:0] mem [32];
    logic [4:0] raddr = '0;

    always #5 CLK = ~CLK;

    ram_seq_ctrl #(.ADDR_W(5), .DATA_W(4), .SCAN_DIV(10), .DEB_CYCLES(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .STEP_N(STEP_N), .LOAD_N(LOAD_N), .MODE(MODE),
        .ADDR_SW(ADDR_SW), .DATA_SW(DATA_SW), .RAM_RDATA(RAM_RDATA),
        .RAM_ADDR(RAM_ADDR), .RAM_DATA(RAM_DATA), .RAM_WE(RAM_WE),
        .DISP_DATA(DISP_DATA), .BUSY(BUSY)
    );

    initial for (int i = 0; i < 32; i++) mem[i] = 4'(i);

    always @(posedge CLK) begin
        if (RAM_WE) mem[RAM_ADDR] <= RAM_DATA;
        raddr <= RAM_ADDR;
    end
    assign RAM_RDATA = mem[raddr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [4:0] a, input logic [3:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("idle_timeout", {31'd0, BUSY}, 32'd0);
    endtask

    task automatic press(input bit do_step, input bit do_load);
        @(negedge CLK);
        if (do_step) STEP_N = 1'b0;
        if (do_load) LOAD_N = 1'b0;
        repeat (6) @(negedge CLK);
        STEP_N = 1'b1;
        LOAD_N = 1'b1;
        repeat (6) @(negedge CLK);
        wait_idle();
    endtask

    task automatic load(input logic [4:0] a);
        ADDR_SW = a;
        press(1'b0, 1'b1);
    endtask

    // Monitor: a completed readback is BUSY falling outside reset.
    initial begin
        logic busy_prev = 1'b0;
        logic [8:0] e;
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                busy_prev = 1'b0;
            end else begin
                if (busy_prev && !BUSY) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_seq: got addr %0d disp %0h expected no sequence",
                                 RAM_ADDR, DISP_DATA);
                    end else begin
                        e = exp_q.pop_front();
                        check("seq_addr", {27'd0, RAM_ADDR}, {27'd0, e[8:4]});
                        check("seq_disp", {28'd0, DISP_DATA}, {28'd0, e[3:0]});
                    end
                end
                busy_prev = BUSY;
            end
        end
    end

    initial begin
        int lat, lat2, we_n, n;
        logic [3:0] v;

        // Reset with inputs toggling.
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            STEP_N  = k[0];
            LOAD_N  = ~k[0];
            MODE    = 2'(k);
            ADDR_SW = 5'(k * 7);
            DATA_SW = 4'(k * 3);
        end
        check("rst_addr", {27'd0, RAM_ADDR}, 32'd0);
        check("rst_data", {28'd0, RAM_DATA}, 32'd0);
        check("rst_we",   {31'd0, RAM_WE}, 32'd0);
        check("rst_disp", {28'd0, DISP_DATA}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        STEP_N = 1'b1;
        LOAD_N = 1'b1;
        MODE   = MODE_READ;
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (10) @(negedge CLK);
        check("post_rst_idle", {31'd0, BUSY}, 32'd0);

        // Write A at 0,1,2; each readback shows the next (unwritten) word.
        MODE    = MODE_WRITE;
        DATA_SW = 4'hA;
        push_exp(5'd1, 4'h1);
        press(1'b1, 1'b0);
        push_exp(5'd2, 4'h2);
        press(1'b1, 1'b0);
        push_exp(5'd3, 4'h3);
        press(1'b1, 1'b0);
        check("write_ptr", {27'd0, RAM_ADDR}, 32'd3);
        MODE = MODE_READ;
        push_exp(5'd1, 4'hA);
        load(5'd1);

        // Wrap-around 31 -> 0 with latency measurement.
        push_exp(5'd31, 4'hF);
        load(5'd31);
        push_exp(5'd0, 4'hA);
        @(negedge CLK);
        STEP_N = 1'b0;
        lat = 0;
        while (RAM_ADDR == 5'd31 && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        check("wrap_addr_lat", lat, 32'd4);
        lat2 = 0;
        while (DISP_DATA !== 4'hA && lat2 < 20) begin
            @(negedge CLK);
            lat2++;
        end
        check("wrap_disp_lat", lat2, 32'd3);
        STEP_N = 1'b1;
        repeat (6) @(negedge CLK);
        wait_idle();

        // Scan: ptr 5 -> 6,7,8 every 10 cycles, then stop on READ.
        push_exp(5'd5, 4'h5);
        load(5'd5);
        push_exp(5'd6, 4'h6);
        push_exp(5'd7, 4'h7);
        push_exp(5'd8, 4'h8);
        @(negedge CLK);
        MODE = MODE_SCAN;
        repeat (9) @(negedge CLK);
        check("scan_before_tick", {27'd0, RAM_ADDR}, 32'd5);
        @(negedge CLK);
        check("scan_tick1", {27'd0, RAM_ADDR}, 32'd6);
        repeat (10) @(negedge CLK);
        check("scan_tick2", {27'd0, RAM_ADDR}, 32'd7);
        repeat (10) @(negedge CLK);
        check("scan_tick3", {27'd0, RAM_ADDR}, 32'd8);
        MODE = MODE_READ;
        wait_idle();
        repeat (30) @(negedge CLK);
        check("scan_stopped", {27'd0, RAM_ADDR}, 32'd8);

        // Load and step in the same cycle: load wins, step dropped.
        ADDR_SW = 5'd20;
        push_exp(5'd20, 4'h4);
        press(1'b1, 1'b1);
        repeat (10) @(negedge CLK);
        check("prio_addr", {27'd0, RAM_ADDR}, 32'd20);

        // Fill memory with F.
        MODE    = MODE_WRITE;
        DATA_SW = 4'hF;
        push_exp(5'd0, 4'hA);
        load(5'd0);
        for (int i = 0; i < 32; i++) begin
            n = i + 1;
            if (n >= 31)     v = 4'hF;
            else if (n <= 2) v = 4'hA;
            else             v = 4'(n);
            push_exp(5'(n), v);
            press(1'b1, 1'b0);
        end

        // Clear, with a second step during the clear that must be ignored.
        MODE = MODE_CLEAR;
        push_exp(5'd0, 4'h0);
        we_n = 0;
        @(negedge CLK);
        STEP_N = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (k == 5)  STEP_N = 1'b1;
            if (k == 12) STEP_N = 1'b0;
            if (k == 17) STEP_N = 1'b1;
            @(negedge CLK);
            if (RAM_WE) we_n++;
        end
        wait_idle();
        check("clear_we_cycles", we_n, 32'd32);
        check("clear_addr", {27'd0, RAM_ADDR}, 32'd0);
        check("clear_disp", {28'd0, DISP_DATA}, 32'd0);
        MODE = MODE_READ;
        push_exp(5'd17, 4'h0);
        load(5'd17);

        // Reset during the write pulse.
        MODE    = MODE_WRITE;
        DATA_SW = 4'h6;
        @(negedge CLK);
        STEP_N = 1'b0;
        lat = 0;
        while (!RAM_WE && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        check("we_lat", lat, 32'd4);
        check("we_addr", {27'd0, RAM_ADDR}, 32'd17);
        RST_N = 1'b0;
        #1;
        check("midrst_we",   {31'd0, RAM_WE}, 32'd0);
        check("midrst_addr", {27'd0, RAM_ADDR}, 32'd0);
        check("midrst_busy", {31'd0, BUSY}, 32'd0);
        check("midrst_disp", {28'd0, DISP_DATA}, 32'd0);
        STEP_N = 1'b1;
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        check("midrst_no_write", {28'd0, mem[17]}, 32'd0);
        // Pointer restarted at 0: write at 0, readback of word 1 (cleared).
        push_exp(5'd1, 4'h0);
        press(1'b1, 1'b0);
        check("post_rst_write", {28'd0, mem[0]}, 32'h6);

        repeat (10) @(negedge CLK);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram_seq_ctrl.md
# ram_seq_ctrl

Address/data sequencer that sits directly upstream of the 32x4 LPM RAM in the lab_05 memory exercise. It turns a raw push-button and slide-switch settings into clean RAM write and read cycles. It provides auto-increment write, step read, timed auto-scan and whole-memory clear. Every pointer change is followed by a readback, so the display register always holds the contents of the current `RAM_ADDR`.

## Interface
Parameters:
- `ADDR_W`, 5: RAM address width; memory depth is 2^ADDR_W.
- `DATA_W`, 4: RAM word width.
- `SCAN_DIV`, 50_000_000: CLK cycles between auto-scan steps.
- `DEB_CYCLES`, 500_000: stable cycles required before a key level is accepted.

Ports (one clock; reset is asynchronous and active-low):
- `CLK`  in  1  system clock; all state changes on its rising edge.
- `RST_N`  in  1  asynchronous active-low reset.
- `STEP_N`  in  1  raw push-button, active-low, asynchronous to CLK.
- `LOAD_N`  in  1  raw push-button, active-low; loads the pointer from `ADDR_SW`.
- `MODE`  in  2  mode select: 00 READ, 01 WRITE, 10 SCAN, 11 CLEAR.
- `ADDR_SW`  in  ADDR_W  address to load.
- `DATA_SW`  in  DATA_W  write data.
- `RAM_RDATA`  in  DATA_W  RAM read port.
- `RAM_ADDR`  out  ADDR_W  RAM address; equals the pointer except during CLEAR.
- `RAM_DATA`  out  DATA_W  RAM write data.
- `RAM_WE`  out  1  RAM write enable, one-cycle pulses only.
- `DISP_DATA`  out  DATA_W  registered readback value.
- `BUSY`  out  1  high while a sequence is in progress.

## Operation
- Key conditioning: each key passes through a 2-flop sync, a debounce stage and a falling-edge detector. The result is a one-cycle event pulse (`step_ev`, `load_ev`).
- Event priority within one cycle: load_ev > step_ev > scan tick.
- Events arriving while BUSY=1 are dropped, not queued.
- FSM states: IDLE, WRITE, ADDR, WAIT, CAPTURE, CLEAR.
- IDLE, load_ev: ptr <= ADDR_SW, then go to ADDR.
- IDLE, step_ev, MODE=READ: ptr <= ptr+1, then go to ADDR.
- IDLE, step_ev, MODE=WRITE: latch DATA_SW into RAM_DATA, then go to WRITE.
- WRITE: RAM_WE=1 at RAM_ADDR=ptr; ptr <= ptr+1; next state ADDR.
- IDLE, step_ev, MODE=CLEAR: clr_cnt <= 0, RAM_DATA <= 0, then go to CLEAR.
- CLEAR: RAM_WE=1 and RAM_ADDR=clr_cnt on each of 2^ADDR_W consecutive cycles. After the last address, ptr <= 0 and go to ADDR.
- MODE=SCAN: a prescaler counts 0..SCAN_DIV-1. On the terminal count it issues a tick; in IDLE the tick does ptr <= ptr+1 and goes to ADDR. The prescaler is held at 0 whenever MODE is not SCAN.
- step_ev in SCAN mode is ignored.
- ADDR: the new address is presented to the RAM; next state WAIT.
- WAIT: RAM_RDATA becomes valid; next state CAPTURE.
- CAPTURE: DISP_DATA <= RAM_RDATA; return to IDLE.
- Arithmetic: ptr and clr_cnt are modulo 2^ADDR_W, so 31+1 = 0 with no flag.
- A MODE change mid-sequence has no effect until IDLE; a CLEAR in progress always completes.

## Timing
- Reset values: RAM_ADDR=0, RAM_DATA=0, RAM_WE=0, DISP_DATA=0, BUSY=0, FSM=IDLE, ptr=0, prescaler=0. No readback is performed after reset.
- Reset asserted mid-sequence: RAM_WE drops asynchronously and the sequence is abandoned; no partial write continues.
- Event pulse at cycle e. All sequence outputs below are registered.
- Read, load or scan event:
  - RAM_ADDR holds the new value from e+1.
  - DISP_DATA holds the new value from e+4.
- Write event:
  - WE pulse in cycle e+1.
  - New ptr on RAM_ADDR from e+2.
  - DISP_DATA updated from e+5.
- Clear event:
  - WE high for cycles e+1 .. e+32.
  - RAM_ADDR returns to 0 at e+33.
  - DISP_DATA becomes 0 from e+36.
- BUSY is high from e+1 through the CAPTURE cycle inclusive.
- Debounce: with the feature enabled, an event fires DEB_CYCLES+3 cycles after a clean falling edge.

## Configuration
- `RAM_SEQ_DEBOUNCE_EN` defined: full debounce with DEB_CYCLES hold, for hardware builds.
- `RAM_SEQ_DEBOUNCE_EN` undefined: sync + edge detect only, so an event fires 3 cycles after the edge. Used for simulation; every other behaviour is identical.

## Structure
- Package `ram_seq_pkg`: MODE encodings (MODE_READ, MODE_WRITE, MODE_SCAN, MODE_CLEAR), FSM state enum, and default ADDR_W/DATA_W constants.
- Sub-module `key_cond` (sync, optional debounce, falling-edge pulse), instantiated twice: once for STEP_N, once for LOAD_N.

## Test plan
Bench builds without `RAM_SEQ_DEBOUNCE_EN`; the bench RAM model has a registered address.

- **Reset:** hold RST_N=0 with toggling inputs -> all outputs 0, BUSY=0.
- **Write then read back:** MODE=01, DATA_SW=A, three STEP presses -> writes A at addresses 0,1,2; RAM_ADDR=3; DISP_DATA = contents of address 3. Then load 1, MODE=00 -> DISP_DATA=A.
- **Wrap-around:** load ADDR_SW=31, READ step -> RAM_ADDR=0; DISP_DATA shows word 0 at e+4.
- **Clear:** fill memory with F, MODE=11, one step -> RAM_WE high for exactly 32 cycles; a step pressed during the clear is ignored; final RAM_ADDR=0, DISP_DATA=0; read of address 17 returns 0.
- **Scan:** SCAN_DIV=10, MODE=10 -> RAM_ADDR increments every 10 cycles. Switch to 00 mid-scan -> the current readback completes and increments stop.
- **Priority and mid-op reset:** LOAD and STEP on the same cycle -> the load is taken and the step dropped. Assert RST_N during a WRITE pulse -> RAM_WE=0 immediately and ptr=0.
